// File: rtl/tone_period_decoder.sv
// tone_period_decoder: measures the half-period of a square-wave tone in
// prescaler ticks. Publishes the measurement on DIVISOR with a one-cycle
// DIV_VALID strobe, and reports a silent line as DIVISOR = 0.
//
// Handshake: DIV_VALID is a one-cycle strobe with no back-pressure. DIVISOR,
// SILENT and STABLE are updated in the same cycle the strobe is high, and
// they hold their values between strobes.
module tone_period_decoder #(
    parameter int PRESCALE_BITS = 13,
    parameter int DIV_WIDTH     = 15,
    parameter int TIMEOUT_TICKS = 32768
) (
    input  logic                 CLK_50MHZ,
    input  logic                 RESET,
    input  logic                 TONE_IN,
    output logic [DIV_WIDTH-1:0] DIVISOR,
    output logic                 DIV_VALID,
    output logic                 SILENT,
    output logic                 STABLE
);

    // Largest interval that fits in DIVISOR; anything longer is treated as silence.
    localparam logic [15:0] MAX_DIV   = 16'((1 << DIV_WIDTH) - 1);
    localparam logic [15:0] TIMEOUT_T = 16'(TIMEOUT_TICKS);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic                     sync1_q, sync2_q, prev_q;
    logic [PRESCALE_BITS-1:0] presc_q;
    logic [15:0]              tcnt_q, tcnt_d;
    logic [DIV_WIDTH-1:0]     divisor_q, divisor_d;
    logic [DIV_WIDTH-1:0]     prev_meas_q, prev_meas_d;
    logic                     valid_q, valid_d;
    logic                     silent_q, silent_d;
    logic                     stable_q, stable_d;

    logic        edge_det;
    logic        tick;
    logic [15:0] tcnt_restart;

    assign edge_det     = sync2_q ^ prev_q;
    assign tick         = &presc_q;
    // An edge landing on a tick opens the new interval with that tick already counted.
    assign tcnt_restart = tick ? 16'd1 : 16'd0;

    // Input synchroniser, edge-history flop and free-running prescaler.
    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            sync1_q <= TONE_IN;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            presc_q <= presc_q + {{(PRESCALE_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Measurement state, tick counter and registered outputs.
    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            divisor_q   <= '0;
            prev_meas_q <= '0;
            valid_q     <= 1'b0;
            silent_q    <= 1'b1;
            stable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            divisor_q   <= divisor_d;
            prev_meas_q <= prev_meas_d;
            valid_q     <= valid_d;
            silent_q    <= silent_d;
            stable_q    <= stable_d;
        end
    end

    // Next-state logic: anchor on the first edge, publish on later edges, time out on silence.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        divisor_d   = divisor_q;
        prev_meas_d = prev_meas_q;
        valid_d     = 1'b0;
        silent_d    = silent_q;
        stable_d    = stable_q;

        unique case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (edge_det) begin
                    tcnt_d  = tcnt_restart;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (edge_det && tcnt_q != 16'd0 && tcnt_q <= MAX_DIV) begin
                    divisor_d   = tcnt_q[DIV_WIDTH-1:0];
                    valid_d     = 1'b1;
                    silent_d    = 1'b0;
                    stable_d    = (tcnt_q[DIV_WIDTH-1:0] == prev_meas_q);
                    prev_meas_d = tcnt_q[DIV_WIDTH-1:0];
                    tcnt_d      = tcnt_restart;
                end else if (edge_det && tcnt_q == 16'd0) begin
                    // Two edges inside one tick window: drop it, restart the interval.
                    tcnt_d = tcnt_restart;
                end else if (edge_det || tcnt_q >= TIMEOUT_T) begin
                    // Either the timeout was reached, or an edge arrived after an
                    // interval too long to publish; both mean the line went silent.
                    divisor_d   = '0;
                    valid_d     = 1'b1;
                    silent_d    = 1'b1;
                    stable_d    = 1'b0;
                    prev_meas_d = '0;
                    tcnt_d      = '0;
                    state_d     = ST_IDLE;
                end else if (tick && tcnt_q < TIMEOUT_T) begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    assign DIVISOR   = divisor_q;
    assign DIV_VALID = valid_q;
    assign SILENT    = silent_q;
    assign STABLE    = stable_q;

endmodule
